// File: rtl/reg_file_sb.sv
// Register file with byte-enabled writes, write-to-read bypass and a
// per-register pending scoreboard with a running pending count.
module reg_file_sb #(
  parameter int DW      = 32,
  parameter int NREG    = 16,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  reg_w_index,
  input  logic [DW-1:0]            wr_data,
  input  logic [DW/8-1:0]          wr_be,
  input  logic                     iss,
  input  logic [$clog2(NREG)-1:0]  iss_index,
  input  logic                     rea,
  input  logic                     reb,
  input  logic [$clog2(NREG)-1:0]  reg_a_index,
  input  logic [$clog2(NREG)-1:0]  reg_b_index,
  output logic [DW-1:0]            rd_value_a,
  output logic [DW-1:0]            rd_value_b,
  output logic                     rd_pend_a,
  output logic                     rd_pend_b,
  output logic [$clog2(NREG):0]    pend_cnt
);

  localparam int AW = $clog2(NREG);
  localparam int NB = DW / 8;
  localparam bit Z0 = (ZERO_R0 != 0);

  logic [DW-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0] cnt_q, cnt_d;

  logic wr_ok, set_ok, inc, dec;
  logic [DW-1:0] be_mask;
  logic [DW-1:0] merged_a, merged_b;

  // Writes to a hardwired r0 and issues to it never take effect.
  always_comb begin
    wr_ok  = we  && !(Z0 && reg_w_index == '0);
    set_ok = iss && !(Z0 && iss_index == '0);
    for (int k = 0; k < NB; k++) begin
      be_mask[8*k +: 8] = {8{wr_be[k]}};
    end
  end

  // Post-write value of the read targets, used when bypassing.
  always_comb begin
    merged_a = (regs_q[reg_a_index] & ~be_mask) | (wr_data & be_mask);
    merged_b = (regs_q[reg_b_index] & ~be_mask) | (wr_data & be_mask);
  end

  // Register storage: byte-lane writes, synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) begin
          regs_q[reg_w_index][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Scoreboard next state: writeback clears, issue sets and wins.
  always_comb begin
    pend_d = pend_q;
    if (we) pend_d[reg_w_index] = 1'b0;
    if (set_ok) pend_d[iss_index] = 1'b1;
    inc = set_ok && !pend_q[iss_index];
    dec = we && pend_q[reg_w_index]
        && !(set_ok && iss_index == reg_w_index);
    cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  // Scoreboard and pending-count state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  // Port a read: stored value, bypassed from a same-cycle write.
  always_comb begin
    rd_value_a = '0;
    rd_pend_a  = 1'b0;
    if (rst_n && rea && !(Z0 && reg_a_index == '0)) begin
      if (we && reg_a_index == reg_w_index) begin
        rd_value_a = merged_a;
        rd_pend_a  = set_ok && iss_index == reg_w_index;
      end else begin
        rd_value_a = regs_q[reg_a_index];
        rd_pend_a  = pend_q[reg_a_index];
      end
    end
  end

  // Port b read: same behaviour as port a.
  always_comb begin
    rd_value_b = '0;
    rd_pend_b  = 1'b0;
    if (rst_n && reb && !(Z0 && reg_b_index == '0)) begin
      if (we && reg_b_index == reg_w_index) begin
        rd_value_b = merged_b;
        rd_pend_b  = set_ok && iss_index == reg_w_index;
      end else begin
        rd_value_b = regs_q[reg_b_index];
        rd_pend_b  = pend_q[reg_b_index];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with a normal r0 and one
// with r0 hardwired to zero, driven from the same stimulus.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [3:0]  reg_w_index;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        iss;
  logic [3:0]  iss_index;
  logic        rea, reb;
  logic [3:0]  reg_a_index, reg_b_index;

  logic [31:0] va, vb, va_z, vb_z;
  logic        pa, pb, pa_z, pb_z;
  logic [4:0]  cnt, cnt_z;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DW(32), .NREG(16), .ZERO_R0(0)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .reg_w_index(reg_w_index),
    .wr_data(wr_data), .wr_be(wr_be), .iss(iss), .iss_index(iss_index),
    .rea(rea), .reb(reb), .reg_a_index(reg_a_index),
    .reg_b_index(reg_b_index), .rd_value_a(va), .rd_value_b(vb),
    .rd_pend_a(pa), .rd_pend_b(pb), .pend_cnt(cnt)
  );

  reg_file_sb #(.DW(32), .NREG(16), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .we(we), .reg_w_index(reg_w_index),
    .wr_data(wr_data), .wr_be(wr_be), .iss(iss), .iss_index(iss_index),
    .rea(rea), .reb(reb), .reg_a_index(reg_a_index),
    .reg_b_index(reg_b_index), .rd_value_a(va_z), .rd_value_b(vb_z),
    .rd_pend_a(pa_z), .rd_pend_b(pb_z), .pend_cnt(cnt_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen at +5.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    #4;
  endtask

  task automatic idle;
    we = 0; iss = 0; wr_be = 4'h0; wr_data = '0;
  endtask

  initial begin
    rst_n = 0; idle(); reg_w_index = 0; iss_index = 0;
    rea = 1; reb = 1; reg_a_index = 3; reg_b_index = 0;
    tick(); tick();
    // outputs held low during reset
    mid();
    chk("rst_va", va, 32'h0);
    chk("rst_pa", {31'b0, pa}, 32'h0);
    chk("rst_cnt", {27'b0, cnt}, 32'h0);
    tick();
    rst_n = 1;

    // full write then partial write with bypass
    we = 1; reg_w_index = 3; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    tick();
    wr_data = 32'h00001234; wr_be = 4'b0011;
    mid();
    chk("be_bypass", va, 32'hDEAD1234);
    tick();
    idle();
    mid();
    chk("be_merge", va, 32'hDEAD1234);
    chk("be_merge_z", va_z, 32'hDEAD1234);
    tick();

    // all-zero byte enables keep data
    we = 1; reg_w_index = 3; wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
    mid();
    chk("be0_bypass", va, 32'hDEAD1234);
    tick();
    idle();
    mid();
    chk("be0_hold", va, 32'hDEAD1234);
    tick();

    // same-cycle bypass, reg 5 on both ports
    we = 1; reg_w_index = 5; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
    reg_a_index = 5; reg_b_index = 5;
    mid();
    chk("byp_a", va, 32'hA5A5A5A5);
    chk("byp_b", vb, 32'hA5A5A5A5);
    tick();
    idle();
    rea = 0;
    mid();
    chk("rea_off", va, 32'h0);
    chk("reb_on", vb, 32'hA5A5A5A5);
    tick();
    rea = 1;

    // scoreboard: issue 2, 7, 2
    iss = 1; iss_index = 2;
    tick();
    mid();
    chk("cnt_1", {27'b0, cnt}, 32'd1);
    tick();
    iss_index = 7;
    tick();
    mid();
    chk("cnt_2", {27'b0, cnt}, 32'd2);
    iss_index = 2;
    tick();
    mid();
    chk("cnt_2b", {27'b0, cnt}, 32'd2);
    tick();
    idle();
    reg_a_index = 7; reg_b_index = 2;
    mid();
    chk("pend_a7", {31'b0, pa}, 32'd1);
    chk("pend_b2", {31'b0, pb}, 32'd1);
    tick();
    // writeback idx 7 hides pending in the same cycle
    we = 1; reg_w_index = 7; wr_data = 32'h0; wr_be = 4'hF;
    mid();
    chk("wb_pend_fwd", {31'b0, pa}, 32'd0);
    tick();
    idle();
    mid();
    chk("wb_cnt", {27'b0, cnt}, 32'd1);
    chk("wb_pend_a", {31'b0, pa}, 32'd0);
    tick();

    // writeback of 2 with no byte enables still clears pending
    we = 1; reg_w_index = 2; wr_be = 4'h0; wr_data = 32'hFFFF0000;
    tick();
    idle();
    reg_a_index = 2;
    mid();
    chk("wb0_cnt", {27'b0, cnt}, 32'd0);
    chk("wb0_data", va, 32'h0);
    chk("wb0_pend", {31'b0, pa}, 32'd0);
    tick();

    // issue and write the same register together: set wins
    iss = 1; iss_index = 4; we = 1; reg_w_index = 4;
    wr_data = 32'h11; wr_be = 4'hF; reg_a_index = 4;
    mid();
    chk("iw_pend_fwd", {31'b0, pa}, 32'd1);
    tick();
    idle();
    mid();
    chk("iw_data", va, 32'h00000011);
    chk("iw_pend", {31'b0, pa}, 32'd1);
    chk("iw_cnt", {27'b0, cnt}, 32'd1);
    tick();

    // set 9 while clearing 4: count unchanged
    iss = 1; iss_index = 9; we = 1; reg_w_index = 4; wr_be = 4'h0;
    tick();
    idle();
    reg_b_index = 9;
    mid();
    chk("swap_cnt", {27'b0, cnt}, 32'd1);
    chk("swap_p4", {31'b0, pa}, 32'd0);
    chk("swap_p9", {31'b0, pb}, 32'd1);
    tick();

    // write non-pending register: count unchanged
    we = 1; reg_w_index = 6; wr_data = 32'h66; wr_be = 4'hF;
    tick();
    idle();
    mid();
    chk("np_cnt", {27'b0, cnt}, 32'd1);
    tick();

    // r0 write and issue, both instances
    we = 1; reg_w_index = 0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    iss = 1; iss_index = 0; reg_a_index = 0;
    mid();
    chk("r0_byp", va, 32'hFFFFFFFF);
    chk("r0_byp_z", va_z, 32'h0);
    chk("r0_pfwd_z", {31'b0, pa_z}, 32'd0);
    tick();
    idle();
    mid();
    chk("r0_data", va, 32'hFFFFFFFF);
    chk("r0_pend", {31'b0, pa}, 32'd1);
    chk("r0_cnt", {27'b0, cnt}, 32'd2);
    chk("r0_data_z", va_z, 32'h0);
    chk("r0_pend_z", {31'b0, pa_z}, 32'd0);
    chk("r0_cnt_z", {27'b0, cnt_z}, 32'd1);
    tick();

    // issue every register: full count without wrap
    iss = 1;
    for (int i = 0; i < 16; i++) begin
      iss_index = 4'(i);
      tick();
    end
    idle();
    mid();
    chk("full_cnt", {27'b0, cnt}, 32'd16);
    chk("full_cnt_z", {27'b0, cnt_z}, 32'd15);
    tick();

    // reset overrides a coincident writeback
    rst_n = 0; we = 1; reg_w_index = 1; wr_data = 32'h12345678;
    wr_be = 4'hF; reg_a_index = 1;
    mid();
    chk("rst_byp", va, 32'h0);
    chk("rst_pnd", {31'b0, pa}, 32'd0);
    tick();
    rst_n = 1; idle();
    mid();
    chk("post_cnt", {27'b0, cnt}, 32'd0);
    chk("post_cnt_z", {27'b0, cnt_z}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      reg_a_index = 4'(i);
      #1;
      chk($sformatf("post_v%0d", i), va, 32'h0);
      chk($sformatf("post_p%0d", i), {31'b0, pa}, 32'd0);
    end
    tick();

    // scoreboard works normally after reset
    iss = 1; iss_index = 3;
    tick();
    idle();
    reg_a_index = 3;
    mid();
    chk("re_cnt", {27'b0, cnt}, 32'd1);
    chk("re_pend", {31'b0, pa}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
